// File: rtl/bus_pkg.sv
// Shared definitions for the two-master data-bus arbiter: FSM encoding,
// master identifiers and default bus widths.
package bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_e;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_AUX = 1'b1;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int TCNT_W = 8;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin choice: on a tie the master that did not
// own the bus last time wins.
module rr_pick2
  import bus_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic owner
);

  always_comb begin
    grant = req0 | req1;
    owner = MASTER_CPU;
    if (req0 && req1) begin
      owner = ~last;
    end else if (req1) begin
      owner = MASTER_AUX;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, one-slave data-bus arbiter. Grants are held until the slave
// acks, the owner drops its strobe, or the BUSY timeout expires.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int          AW      = DEF_AW,
  parameter int          DW      = DEF_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_data_o,
  input  logic          m0_we,
  input  logic          m0_stb,
  output logic [DW-1:0] m0_data_i,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_data_o,
  input  logic          m1_we,
  input  logic          m1_stb,
  output logic [DW-1:0] m1_data_i,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_data_o,
  output logic          s_we,
  output logic          s_stb,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_ack
);

  localparam logic [TCNT_W-1:0] TLIMIT = TCNT_W'(TIMEOUT - 1);

  bus_state_e        state, state_nx;
  logic              owner, owner_nx;
  logic              last, last_nx;
  logic [TCNT_W-1:0] tcnt, tcnt_nx;

  logic pick_grant;
  logic pick_owner;
  logic busy;
  logic own_stb;
  logic xfer_ack;
  logic xfer_err;

  rr_pick2 u_pick (
    .req0  (m0_stb),
    .req1  (m1_stb),
    .last  (last),
    .grant (pick_grant),
    .owner (pick_owner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= MASTER_CPU;
      last  <= MASTER_AUX;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      tcnt  <= tcnt_nx;
    end
  end

  assign busy     = (state == BUSY);
  assign own_stb  = busy & ((owner == MASTER_AUX) ? m1_stb : m0_stb);
  assign xfer_ack = own_stb & s_ack;
  // Ack has priority over an expiring timeout in the same cycle.
  assign xfer_err = own_stb & ~s_ack & (tcnt == TLIMIT);

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    tcnt_nx  = tcnt;
    case (state)
      IDLE: begin
        if (pick_grant) begin
          state_nx = BUSY;
          owner_nx = pick_owner;
          tcnt_nx  = '0;
        end
      end
      BUSY: begin
        // Completion, abort and timeout all hand priority to the other master.
        if (!own_stb || xfer_ack || xfer_err) begin
          state_nx = IDLE;
          last_nx  = owner;
        end else if (tcnt != '1) begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_addr    = '0;
    s_data_o  = '0;
    s_we      = 1'b0;
    s_stb     = 1'b0;
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m0_data_i = '0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    m1_data_i = '0;
    if (busy) begin
      s_stb = own_stb & ~xfer_err;
      if (owner == MASTER_AUX) begin
        s_addr    = m1_addr;
        s_data_o  = m1_data_o;
        s_we      = m1_we;
        m1_ack    = xfer_ack;
        m1_err    = xfer_err;
        m1_data_i = xfer_ack ? s_data_i : '0;
      end else begin
        s_addr    = m0_addr;
        s_data_o  = m0_data_o;
        s_we      = m0_we;
        m0_ack    = xfer_ack;
        m0_err    = xfer_err;
        m0_data_i = xfer_ack ? s_data_i : '0;
      end
    end
  end

endmodule
